// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared encodings for the multicycle CPU control path. The datapath,
// ALU-control decoder and main control FSM all use these definitions.
//   - FSM state codes (4-bit localparams, legacy-compatible)
//   - OP_* opcode field values
//   - ALU_* codes for the ALU-control decoder P input
//   - ALUSRCB_* and PCSRC_* mux select encodings
//   - ctrl_t: bundle of every datapath control output
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

    localparam int STATE_W = 4;

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXEC_R  = 4'd6;
    localparam logic [3:0] S_ALUWB_R = 4'd7;
    localparam logic [3:0] S_EXEC_I  = 4'd8;
    localparam logic [3:0] S_ALUWB_I = 4'd9;
    localparam logic [3:0] S_BRANCH  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;

    localparam logic [2:0] OP_ANDI  = 3'b000;
    localparam logic [2:0] OP_ORI   = 3'b001;
    localparam logic [2:0] OP_ADDI  = 3'b010;
    localparam logic [2:0] OP_J     = 3'b011;
    localparam logic [2:0] OP_LW    = 3'b100;
    localparam logic [2:0] OP_SW    = 3'b101;
    localparam logic [2:0] OP_BEQ   = 3'b110;
    localparam logic [2:0] OP_RTYPE = 3'b111;

    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b110;
    localparam logic [2:0] ALU_RTYPE = 3'b111;

    localparam logic [1:0] ALUSRCB_REGB    = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       instr_done;
    } ctrl_t;

    // ANDI/ORI/ADDI share one execute path; the opcode doubles as the ALU code.
    function automatic logic is_itype(input logic [2:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multicycle_next_state.sv
// -----------------------------------------------------------------------------
// multicycle_next_state
// Combinational next-state decode for the multicycle control FSM.
// Ports:
//   state      in  4  current FSM state
//   opcode     in  3  IR opcode field (meaningful from DECODE onward)
//   mem_ready  in  1  memory handshake; access completes when high
//   next_state out 4  state to load on the next rising edge
// Unused state encodings steer back to FETCH.
// -----------------------------------------------------------------------------
module multicycle_next_state
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic [2:0] opcode,
    input  logic       mem_ready,
    output logic [3:0] next_state
);

    // Next-state selection from current state, opcode and memory handshake.
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH: begin
                if (mem_ready) begin
                    next_state = S_DECODE;
                end else begin
                    next_state = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:              next_state = S_MEMADR;
                    OP_RTYPE:                  next_state = S_EXEC_R;
                    OP_BEQ:                    next_state = S_BRANCH;
                    OP_J:                      next_state = S_JUMP;
                    OP_ANDI, OP_ORI, OP_ADDI:  next_state = S_EXEC_I;
                    default:                   next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                // Only LW and SW reach here, so anything but LW is a store.
                if (opcode == OP_LW) begin
                    next_state = S_MEMRD;
                end else begin
                    next_state = S_MEMWR;
                end
            end
            S_MEMRD: begin
                if (mem_ready) begin
                    next_state = S_MEMWB;
                end else begin
                    next_state = S_MEMRD;
                end
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    next_state = S_FETCH;
                end else begin
                    next_state = S_MEMWR;
                end
            end
            S_EXEC_R:  next_state = S_ALUWB_R;
            S_EXEC_I:  next_state = S_ALUWB_I;
            S_MEMWB,
            S_ALUWB_R,
            S_ALUWB_I,
            S_BRANCH,
            S_JUMP:    next_state = S_FETCH;
            default:   next_state = S_FETCH;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Main control FSM of the multicycle CPU: sequences fetch, decode, execute,
// memory and writeback, and drives datapath strobes, mux selects and the
// alu_op code consumed by the ALU-control decoder. Never looks at funct.
//
// Parameters:
//   CNT_W        width of the optional performance counters
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high; forces all outputs to 0
//   opcode[2:0]  in   IR opcode field
//   zero         in   ALU zero flag (used in BRANCH)
//   mem_ready    in   memory handshake
//   pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst,
//   mem_to_reg, alu_src_a, alu_src_b[1:0], alu_op[2:0], pc_src[1:0]
//                out  datapath controls
//   instr_done   out  pulse on the last cycle of each instruction
//   cycle_count, instr_count [CNT_W-1:0]
//                out  only when MULTICYCLE_PERF_EN is defined
//
// Build option: define MULTICYCLE_PERF_EN to add the performance counters.
// -----------------------------------------------------------------------------
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             instr_done
`ifdef MULTICYCLE_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("multicycle_control: CNT_W must be at least 1");
    end

    logic [3:0] state_q;
    logic [3:0] state_d;
    ctrl_t      ctrl_s;
    ctrl_t      out_s;

    multicycle_next_state u_next_state (
        .state      (state_q),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .next_state (state_d)
    );

    // State register with synchronous reset back to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore decode of controls; only handshake strobes look at mem_ready/zero.
    always_comb begin
        ctrl_s        = '0;
        ctrl_s.alu_op = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ctrl_s.mem_read  = 1'b1;
                ctrl_s.alu_src_b = ALUSRCB_FOUR;
                ctrl_s.ir_write  = mem_ready;
                ctrl_s.pc_write  = mem_ready;
            end
            S_DECODE: begin
                // Precompute branch target into ALUOut.
                ctrl_s.alu_src_b = ALUSRCB_IMM_SL2;
            end
            S_MEMADR: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = ALUSRCB_IMM;
            end
            S_MEMRD: begin
                ctrl_s.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.mem_to_reg = 1'b1;
                ctrl_s.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl_s.mem_write  = 1'b1;
                ctrl_s.instr_done = mem_ready;
            end
            S_EXEC_R: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = ALUSRCB_REGB;
                ctrl_s.alu_op    = ALU_RTYPE;
            end
            S_ALUWB_R: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.reg_dst    = 1'b1;
                ctrl_s.instr_done = 1'b1;
            end
            S_EXEC_I: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = ALUSRCB_IMM;
                // The ALU-control decoder passes I-type opcodes straight through.
                if (is_itype(opcode)) begin
                    ctrl_s.alu_op = opcode;
                end else begin
                    ctrl_s.alu_op = ALU_ADD;
                end
            end
            S_ALUWB_I: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_s.alu_src_a  = 1'b1;
                ctrl_s.alu_src_b  = ALUSRCB_REGB;
                ctrl_s.alu_op     = ALU_SUB;
                ctrl_s.pc_src     = PCSRC_ALUOUT;
                ctrl_s.pc_write   = zero;
                ctrl_s.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl_s.pc_src     = PCSRC_JUMP;
                ctrl_s.pc_write   = 1'b1;
                ctrl_s.instr_done = 1'b1;
            end
            default: begin
                ctrl_s        = '0;
                ctrl_s.alu_op = ALU_ADD;
            end
        endcase
    end

    // Reset overrides everything, including alu_op, so the datapath sees no strobes.
    always_comb begin
        if (reset) begin
            out_s = '0;
        end else begin
            out_s = ctrl_s;
        end
    end

    assign pc_write   = out_s.pc_write;
    assign ir_write   = out_s.ir_write;
    assign mem_read   = out_s.mem_read;
    assign mem_write  = out_s.mem_write;
    assign reg_write  = out_s.reg_write;
    assign reg_dst    = out_s.reg_dst;
    assign mem_to_reg = out_s.mem_to_reg;
    assign alu_src_a  = out_s.alu_src_a;
    assign alu_src_b  = out_s.alu_src_b;
    assign alu_op     = out_s.alu_op;
    assign pc_src     = out_s.pc_src;
    assign instr_done = out_s.instr_done;

`ifdef MULTICYCLE_PERF_EN
    logic [CNT_W-1:0] cycle_count_q;
    logic [CNT_W-1:0] cycle_count_d;
    logic [CNT_W-1:0] instr_count_q;
    logic [CNT_W-1:0] instr_count_d;

    // Counter increments; both wrap naturally at 2^CNT_W.
    always_comb begin
        cycle_count_d = cycle_count_q + CNT_W'(1'b1);
        if (out_s.instr_done) begin
            instr_count_d = instr_count_q + CNT_W'(1'b1);
        end else begin
            instr_count_d = instr_count_q;
        end
    end

    // Performance counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count_q <= '0;
            instr_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign cycle_count = cycle_count_q;
    assign instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
// Self-checking bench for multicycle_control. The reference model expands
// each instruction into the list of control vectors it must produce, cycle
// by cycle, straight from the per-instruction step tables, and the bench
// compares the DUT against that list while randomising stalls and the
// inputs the FSM must ignore.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, ir_write, mem_read, mem_write, reg_write;
    logic        reg_dst, mem_to_reg, alu_src_a, instr_done;
    logic [1:0]  alu_src_b, pc_src;
    logic [2:0]  alu_op;
`ifdef MULTICYCLE_PERF_EN
    logic [31:0] cycle_count, instr_count;
`endif

    int n_checks  = 0;
    int n_fail    = 0;
    int done_obs  = 0;   // instr_done pulses seen on the DUT
    int cyc_acc   = 0;   // cycles stepped since the last reset release

    logic [15:0] obs;
    assign obs = {pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, instr_done};

    always #5 clk = ~clk;

    multicycle_control #(.CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .instr_done (instr_done)
`ifdef MULTICYCLE_PERF_EN
        ,
        .cycle_count(cycle_count),
        .instr_count(instr_count)
`endif
    );

    function automatic logic [15:0] cv(input logic pcw, input logic irw,
                                       input logic mr, input logic mw,
                                       input logic rw, input logic rd,
                                       input logic m2r, input logic sa,
                                       input logic [1:0] sb, input logic [2:0] aop,
                                       input logic [1:0] ps, input logic dn);
        return {pcw, irw, mr, mw, rw, rd, m2r, sa, sb, aop, ps, dn};
    endfunction

    // Run one instruction (optionally only its first stop_at cycles).
    // sf = FETCH wait cycles, sm = data-memory wait cycles.
    // rdy code per cycle: 0/1 forced, 2 = don't care (randomised).
    task automatic run_instr(input logic [2:0] op, input logic zb, input int sf,
                             input int sm, input int stop_at, input string tag);
        logic [15:0] exp_q[$];
        int          rdy_q[$];
        int          n;
        for (int i = 0; i < sf; i++) begin
            exp_q.push_back(cv(0,0,1,0,0,0,0,0,2'b01,3'b010,2'b00,0)); rdy_q.push_back(0);
        end
        exp_q.push_back(cv(1,1,1,0,0,0,0,0,2'b01,3'b010,2'b00,0)); rdy_q.push_back(1);
        exp_q.push_back(cv(0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0)); rdy_q.push_back(2);
        case (op)
            3'b100: begin // LW
                exp_q.push_back(cv(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0)); rdy_q.push_back(2);
                for (int i = 0; i < sm; i++) begin
                    exp_q.push_back(cv(0,0,1,0,0,0,0,0,2'b00,3'b010,2'b00,0)); rdy_q.push_back(0);
                end
                exp_q.push_back(cv(0,0,1,0,0,0,0,0,2'b00,3'b010,2'b00,0)); rdy_q.push_back(1);
                exp_q.push_back(cv(0,0,0,0,1,0,1,0,2'b00,3'b010,2'b00,1)); rdy_q.push_back(2);
            end
            3'b101: begin // SW
                exp_q.push_back(cv(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0)); rdy_q.push_back(2);
                for (int i = 0; i < sm; i++) begin
                    exp_q.push_back(cv(0,0,0,1,0,0,0,0,2'b00,3'b010,2'b00,0)); rdy_q.push_back(0);
                end
                exp_q.push_back(cv(0,0,0,1,0,0,0,0,2'b00,3'b010,2'b00,1)); rdy_q.push_back(1);
            end
            3'b111: begin // RTYPE
                exp_q.push_back(cv(0,0,0,0,0,0,0,1,2'b00,3'b111,2'b00,0)); rdy_q.push_back(2);
                exp_q.push_back(cv(0,0,0,0,1,1,0,0,2'b00,3'b010,2'b00,1)); rdy_q.push_back(2);
            end
            3'b110: begin // BEQ
                exp_q.push_back(cv(zb,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,1)); rdy_q.push_back(2);
            end
            3'b011: begin // J
                exp_q.push_back(cv(1,0,0,0,0,0,0,0,2'b00,3'b010,2'b10,1)); rdy_q.push_back(2);
            end
            default: begin // ANDI / ORI / ADDI
                exp_q.push_back(cv(0,0,0,0,0,0,0,1,2'b10,op,2'b00,0)); rdy_q.push_back(2);
                exp_q.push_back(cv(0,0,0,0,1,0,0,0,2'b00,3'b010,2'b00,1)); rdy_q.push_back(2);
            end
        endcase
        n = exp_q.size();
        if (stop_at >= 0 && stop_at < n) n = stop_at;
        for (int i = 0; i < n; i++) begin
            // During FETCH the opcode field is stale; drive garbage there.
            opcode    = (i <= sf) ? 3'($urandom) : op;
            zero      = zb;
            mem_ready = (rdy_q[i] == 2) ? 1'($urandom) : rdy_q[i][0];
            #1;
            n_checks++;
            if (obs !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s cycle %0d: ctrl got %h expected %h", tag, i, obs, exp_q[i]);
            end
            if (obs[0] === 1'b1) done_obs++;
            cyc_acc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            opcode    = 3'($urandom);
            zero      = 1'($urandom);
            mem_ready = 1'($urandom);
            #1;
            n_checks++;
            if (obs !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got %h expected 0000", i, obs);
            end
            @(negedge clk);
        end
        reset   = 1'b0;
        cyc_acc = 0;
    endtask

    task automatic test_lw();
        int d0 = done_obs;
        run_instr(3'b100, 1'b0, 0, 0, -1, "lw");
        n_checks++;
        if (done_obs - d0 !== 1) begin
            n_fail++;
            $display("FAIL lw_done_count: got %0d expected 1", done_obs - d0);
        end
        run_instr(3'b100, 1'b1, 2, 2, -1, "lw_stall");
    endtask

    task automatic test_sw_stall();
        int d0 = done_obs;
        run_instr(3'b101, 1'b0, 0, 3, -1, "sw_stall");
        n_checks++;
        if (done_obs - d0 !== 1) begin
            n_fail++;
            $display("FAIL sw_done_count: got %0d expected 1", done_obs - d0);
        end
    endtask

    task automatic test_beq();
        run_instr(3'b110, 1'b1, 0, 0, -1, "beq_taken");
        run_instr(3'b110, 1'b0, 0, 0, -1, "beq_not_taken");
        run_instr(3'b011, 1'b0, 1, 0, -1, "jump");
    endtask

    task automatic test_alu_ops();
        run_instr(3'b111, 1'b0, 0, 0, -1, "rtype");
        run_instr(3'b010, 1'b0, 0, 0, -1, "addi");
        run_instr(3'b000, 1'b1, 0, 0, -1, "andi");
        run_instr(3'b001, 1'b0, 1, 0, -1, "ori");
    endtask

    task automatic test_reset_mid();
        int d0;
        run_instr(3'b100, 1'b0, 0, 3, 4, "lw_abort");   // parked in MEMRD
        d0        = done_obs;
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        n_checks++;
        if (obs !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %h expected 0000", obs);
        end
        if (obs[0] === 1'b1) done_obs++;
        @(negedge clk);
        reset = 1'b0;
        run_instr(3'b011, 1'b0, 0, 0, -1, "after_reset_j");
        n_checks++;
        if (done_obs - d0 !== 1) begin
            n_fail++;
            $display("FAIL reset_mid_done_count: got %0d expected 1", done_obs - d0);
        end
    endtask

    task automatic test_back_to_back();
        int d0 = done_obs;
        for (int k = 0; k < 30; k++) begin
            run_instr(3'($urandom), 1'($urandom), $urandom_range(0, 2),
                      $urandom_range(0, 3), -1, "random");
        end
        n_checks++;
        if (done_obs - d0 !== 30) begin
            n_fail++;
            $display("FAIL random_done_count: got %0d expected 30", done_obs - d0);
        end
    endtask

    task automatic test_perf();
`ifdef MULTICYCLE_PERF_EN
        logic [2:0] ops [10] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100,
                                 3'b101, 3'b110, 3'b111, 3'b100, 3'b101};
        test_reset();
        for (int k = 0; k < 10; k++) begin
            run_instr(ops[k], 1'($urandom), $urandom_range(0, 1),
                      $urandom_range(0, 2), -1, "perf");
        end
        n_checks++;
        if (instr_count !== 32'd10) begin
            n_fail++;
            $display("FAIL perf_instr_count: got %0d expected 10", instr_count);
        end
        n_checks++;
        if (cycle_count !== 32'(cyc_acc)) begin
            n_fail++;
            $display("FAIL perf_cycle_count: got %0d expected %0d", cycle_count, cyc_acc);
        end
`endif
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = 3'b000;
        zero      = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_lw();
        test_sw_stall();
        test_beq();
        test_alu_ops();
        test_reset_mid();
        test_back_to_back();
        test_perf();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
